// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the multi-port register file.
//   rf_state_e  : sweep/run state of the register file
//   byte_merge  : per-byte merge of a new word over an old word, used by both
//                 the storage write path and the read-port bypass so the two
//                 can never disagree.
// -----------------------------------------------------------------------------
package regfile_pkg;

   // Widest data word the merge helper handles; callers zero-extend into it
   // and truncate the result back to their own DATA_W.
   localparam int RF_MAX_W  = 1024;
   localparam int RF_MAX_BE = RF_MAX_W / 8;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_IDLE  = 1'b1
   } rf_state_e;

   function automatic logic [RF_MAX_W-1:0] byte_merge(
      input logic [RF_MAX_W-1:0]  old_w,
      input logic [RF_MAX_W-1:0]  new_w,
      input logic [RF_MAX_BE-1:0] be
   );
      logic [RF_MAX_W-1:0] res;
      res = old_w;
      for (int k = 0; k < RF_MAX_BE; k++) begin
         if (be[k]) begin
            res[8*k +: 8] = new_w[8*k +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if
// Bus between the datapath (decode/writeback, master) and the register file
// (slave).
//   we/waddr/wdata/wbe : write port, wbe bit k gates wdata[8k+7:8k]
//   raddr              : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   clear_req          : level-sampled request to sweep the array to zero
//   rdata              : packed read data, port i at [i*DATA_W +: DATA_W]
//   busy               : clear sweep in progress
//   wr_dropped         : one-cycle pulse, a write was discarded
// -----------------------------------------------------------------------------
interface regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                       we;
   logic [ADDR_W-1:0]          waddr;
   logic [DATA_W-1:0]          wdata;
   logic [DATA_W/8-1:0]        wbe;
   logic [NUM_RD*ADDR_W-1:0]   raddr;
   logic                       clear_req;
   logic [NUM_RD*DATA_W-1:0]   rdata;
   logic                       busy;
   logic                       wr_dropped;

   modport master (
      output we, waddr, wdata, wbe, raddr, clear_req,
      input  rdata, busy, wr_dropped
   );

   modport slave (
      input  we, waddr, wdata, wbe, raddr, clear_req,
      output rdata, busy, wr_dropped
   );
endinterface

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One combinational read port of the register file.
//   mem_i       : the storage array
//   raddr_i     : read address for this port
//   busy_i      : clear sweep active, forces zero output
//   wr_accept_i : the write on waddr_i/wdata_i/wbe_i commits at the next edge
//   rdata_o     : read data (bypassed merged value on an address match)
// -----------------------------------------------------------------------------
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int ZERO_R0 = 1
) (
   input  logic [DATA_W-1:0]   mem_i [2**ADDR_W],
   input  logic [ADDR_W-1:0]   raddr_i,
   input  logic                busy_i,
   input  logic                wr_accept_i,
   input  logic [ADDR_W-1:0]   waddr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wbe_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] stored_w;
   logic [DATA_W-1:0] merged_w;
   logic              zero_hit_w;

   assign stored_w   = mem_i[raddr_i];
   assign merged_w   = DATA_W'(byte_merge(RF_MAX_W'(stored_w), RF_MAX_W'(wdata_i),
                                          RF_MAX_BE'(wbe_i)));
   assign zero_hit_w = (ZERO_R0 != 0) && (raddr_i == '0);

   // Masking is applied last so a zero register or an active sweep always
   // wins over the bypass path.
   always_comb begin
      rdata_o = stored_w;
      if (wr_accept_i && (waddr_i == raddr_i)) begin
         rdata_o = merged_w;
      end
      if (busy_i || zero_hit_w) begin
         rdata_o = '0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-read-port register file with per-byte write enables,
// write-to-read bypass, optional hardwired zero entry and a clear sequencer
// that sweeps every entry to zero after reset or on clear_req.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (forces a fresh sweep)
//   bus   : regfile_if slave modport (write port, read ports, clear, status)
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_RD  = 2,
   parameter int ZERO_R0 = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   regfile_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   // Storage is intentionally not reset; the sweep zeroes it.
   logic [DATA_W-1:0] mem_q [DEPTH];

   rf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              dropped_q, dropped_d;

   logic              busy_w;
   logic              wr_zero_w;
   logic              wr_accept_w;
   logic [DATA_W-1:0] wr_merged_w;
   logic [DATA_W-1:0] rd_data_w [NUM_RD];

   assign busy_w    = (state_q == RF_CLEAR);
   assign wr_zero_w = (ZERO_R0 != 0) && (bus.waddr == '0);

   // A write commits only in IDLE with no clear pending; writes to the zero
   // entry are swallowed silently (neither committed nor reported).
   assign wr_accept_w = bus.we && !busy_w && !bus.clear_req && !wr_zero_w;
   assign wr_merged_w = DATA_W'(byte_merge(RF_MAX_W'(mem_q[bus.waddr]),
                                           RF_MAX_W'(bus.wdata),
                                           RF_MAX_BE'(bus.wbe)));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RF_CLEAR;
         cnt_q     <= '0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dropped_q <= dropped_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      // Clear takes priority over a same-cycle write, which is reported lost.
      dropped_d = bus.we && (busy_w || bus.clear_req);
      unique case (state_q)
         RF_CLEAR: begin
            // Counter wraps to 0 naturally on the last entry.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = RF_IDLE;
            end
         end
         RF_IDLE: begin
            if (bus.clear_req) begin
               state_d = RF_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RF_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------ storage
   always_ff @(posedge clk) begin
      if (busy_w) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_accept_w) begin
         mem_q[bus.waddr] <= wr_merged_w;
      end
   end

   // --------------------------------------------------------- read ports
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_rd_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_R0 (ZERO_R0)
      ) u_rd_port (
         .mem_i       (mem_q),
         .raddr_i     (bus.raddr[gi*ADDR_W +: ADDR_W]),
         .busy_i      (busy_w),
         .wr_accept_i (wr_accept_w),
         .waddr_i     (bus.waddr),
         .wdata_i     (bus.wdata),
         .wbe_i       (bus.wbe),
         .rdata_o     (rd_data_w[gi])
      );
   end

   always_comb begin
      bus.rdata = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         bus.rdata[i*DATA_W +: DATA_W] = rd_data_w[i];
      end
   end

   assign bus.busy       = busy_w;
   assign bus.wr_dropped = dropped_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next generation of the CPU's 32x32 register file. It adds configurable width, depth and read-port count, per-byte write enables, and write-to-read bypass. It also adds an optional hardwired zero register and a hardware clear sequencer that sweeps every entry to zero after reset or on request. It sits between decode (read addresses) and writeback (write port) in the datapath.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_R0, 1, when 1 entry 0 always reads 0 and ignores writes
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write request
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- wbe  in  DATA_W/8  byte enables; bit k gates wdata[8k+7:8k]
- raddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
- clear_req  in  1  request full-array clear (level-sampled)
- busy  out  1  clear sweep in progress
- wr_dropped  out  1  one-cycle pulse: a write was discarded

## Operation
- FSM states: CLEAR, IDLE. Reset forces CLEAR with sweep counter = 0.
- CLEAR: each rising edge writes 0 to entry[cnt] and increments cnt. On the edge that clears entry DEPTH-1, go to IDLE and drop busy. cnt wraps to 0.
- IDLE: clear_req=1 at an edge moves the FSM to CLEAR with cnt=0. The entry at cnt 0 is cleared on the following edge.
- Write (IDLE, we=1, clear_req=0): bytes with wbe[k]=1 are updated at the edge; other bytes are kept. wbe=0 is a legal no-op and does not set wr_dropped.
- Write to entry 0 with ZERO_R0=1: ignored silently, no wr_dropped.
- Write while busy=1, or with clear_req=1 in the same IDLE cycle: discarded, and wr_dropped=1 in the next cycle. Clear wins.
- Read (combinational):
  - busy=1: rdata = 0 on all ports.
  - Otherwise rdata = entry[raddr[i]].
  - Bypass: if we=1, the write is accepted this cycle, and waddr==raddr[i], rdata shows the merged value (enabled bytes from wdata, the rest from the stored entry).
- ZERO_R0=1 and raddr[i]==0: rdata port i = 0 regardless of bypass.
- Multiple ports reading the same address get identical data.

## Timing
- Reset values: busy=1, wr_dropped=0, rdata=0, FSM=CLEAR, cnt=0. Array contents are not reset; the sweep zeroes them.
- After rst_n deasserts, busy falls after exactly DEPTH rising edges (32 for defaults). The first non-dropped write is possible in the cycle busy=0.
- Write latency: the value is visible via bypass in the same cycle and from storage from the next cycle.
- clear_req during CLEAR is ignored; the sweep does not restart.
- Reset asserted mid-sweep: immediate return to CLEAR, cnt=0, full sweep repeats.
- wr_dropped is registered and high for exactly one cycle per dropped write.

## Structure
- Package regfile_pkg holds:
  - FSM state enum (RF_CLEAR, RF_IDLE)
  - byte-merge function (old, new, be) → merged word, shared by storage write and bypass
- Sub-module regfile_rd_port, instantiated NUM_RD times via generate. It does array select, zero-reg masking, busy masking and bypass for one port.
- Top holds the array, FSM, counter and write logic.

## Test plan
- Reset release, defaults → busy=1 for 32 cycles, rdata=0 throughout; busy=0 on cycle 32; every address reads 0x00000000.
- Write 0xDEADBEEF to r5 with wbe=4'b1111, then wbe=4'b0101 with wdata=0x11223344 → read 0xDE22BE44. The bypass port shows the same value in the write cycle.
- Write 0xFFFFFFFF to r0 with ZERO_R0=1 → both ports read r0 = 0; wr_dropped stays 0.
- we=1 with clear_req=1 in the same IDLE cycle → write discarded, wr_dropped pulses once, busy high 32 cycles, r7 (preloaded 0x12345678) reads 0 after.
- Assert rst_n low at sweep count 10, release → busy stays high a full 32 cycles from release.
- NUM_RD=4, all ports raddr=3 with r3=0xA5A5A5A5 → all four rdata = 0xA5A5A5A5.
